// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared scan-state type and BCD helpers for the stopwatch display
//
// Contents:
//   scan_state_e  : scan controller states (IDLE / BLANK / ON)
//   BCD_MAX       : largest code the seven-segment decoder understands
//   bcd_or_zero() : maps non-BCD codes (10..15) to 0 so the decoder never sees them
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

    function automatic logic [3:0] bcd_or_zero(input logic [3:0] d);
        return bcd_valid(d) ? d : 4'd0;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - slot cycle counter and digit index counter for the display scan
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr_i           : synchronous clear of both counters (controller idle or disabled)
//   run_i           : advance the slot counter this cycle
//   idx_o           : digit index of the current slot
//   blank_end_o     : last dark cycle of the slot (cnt = BLANK_CYCLES-1)
//   slot_end_o      : last cycle of the slot (cnt = SCAN_DIV-1)
//   frame_wrap_o    : slot_end_o on the last digit of the frame
module scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          run_i,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
    output logic                          blank_end_o,
    output logic                          slot_end_o,
    output logic                          frame_wrap_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign blank_end_o  = run_i && (cnt_q == BLANK_LAST);
    assign slot_end_o   = run_i && (cnt_q == CNT_LAST);
    assign frame_wrap_o = slot_end_o && (idx_q == IDX_LAST);
    assign idx_o        = idx_q;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clr_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (run_i) begin
            if (slot_end_o) begin
                cnt_d = '0;
                idx_d = frame_wrap_o ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - time-multiplexed scan of a shared seven-segment decoder
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : scan enable; low parks the controller in IDLE with the display dark
//   lz_en         : leading-zero suppression, sampled with each frame snapshot
//   digits_in     : packed BCD word, digit 0 in bits [3:0]
//   number        : code to the decoder (always 0..9)
//   digit_sel     : one-hot digit enable, all-zero = dark
//   frame_start   : one-cycle pulse on the first cycle of each frame
module display_scan_controller
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      lz_en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    output logic [3:0]                number,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    scan_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   sup_q, sup_d;
    logic [3:0]              number_q, number_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_start_q, frame_start_d;

    logic [IDX_W-1:0]        idx;
    logic                    blank_end;
    logic                    slot_end;
    logic                    frame_wrap;
    logic                    timer_clr;
    logic                    timer_run;

    // A digit is suppressed only while every digit above it is zero; the
    // running flag drops at the first non-zero (or non-BCD) digit from the top.
    // Digit 0 is left out so a zero reading still shows a single 0.
    function automatic logic [NUM_DIGITS-1:0] calc_sup(
        input logic [4*NUM_DIGITS-1:0] w,
        input logic                    lz
    );
        logic [NUM_DIGITS-1:0] s;
        logic                  zero_run;
        s        = '0;
        zero_run = lz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (w[4*k +: 4] == 4'd0);
            s[k]     = zero_run;
        end
        return s;
    endfunction

    function automatic logic [3:0] get_digit(
        input logic [4*NUM_DIGITS-1:0] w,
        input logic [IDX_W-1:0]        i
    );
        logic [3:0] d;
        d = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i == IDX_W'(k)) begin
                d = w[4*k +: 4];
            end
        end
        return d;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IDX_W-1:0] i);
        logic [NUM_DIGITS-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            s[k] = (i == IDX_W'(k));
        end
        return s;
    endfunction

    // Counters are held at zero whenever the controller is idle or disabled,
    // so the first BLANK cycle after enable always starts at cnt = 0, idx = 0.
    assign timer_clr = !en || (state_q == ST_IDLE);
    assign timer_run = en && (state_q != ST_IDLE);

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (timer_clr),
        .run_i        (timer_run),
        .idx_o        (idx),
        .blank_end_o  (blank_end),
        .slot_end_o   (slot_end),
        .frame_wrap_o (frame_wrap)
    );

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        sup_d         = sup_q;
        number_d      = number_q;
        digit_sel_d   = digit_sel_q;
        frame_start_d = 1'b0;

        if (!en) begin
            // number deliberately holds; only the enables go dark
            state_d     = ST_IDLE;
            digit_sel_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_d        = digits_in;
                    sup_d         = calc_sup(digits_in, lz_en);
                    number_d      = bcd_or_zero(digits_in[3:0]);
                    frame_start_d = 1'b1;
                    digit_sel_d   = '0;
                    state_d       = ST_BLANK;
                end
                ST_BLANK: begin
                    digit_sel_d = '0;
                    if (blank_end) begin
                        state_d = ST_ON;
                        // suppressed or non-BCD slots stay dark for the whole slot
                        if (((sup_q & one_hot(idx)) == '0) &&
                            bcd_valid(get_digit(snap_q, idx))) begin
                            digit_sel_d = one_hot(idx);
                        end
                    end
                end
                ST_ON: begin
                    if (slot_end) begin
                        state_d     = ST_BLANK;
                        digit_sel_d = '0;
                        if (frame_wrap) begin
                            // new frame: the decoder code comes from the fresh snapshot
                            snap_d        = digits_in;
                            sup_d         = calc_sup(digits_in, lz_en);
                            number_d      = bcd_or_zero(digits_in[3:0]);
                            frame_start_d = 1'b1;
                        end else begin
                            number_d = bcd_or_zero(get_digit(snap_q, idx + 1'b1));
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    digit_sel_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            snap_q        <= '0;
            sup_q         <= '0;
            number_q      <= 4'd0;
            digit_sel_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            sup_q         <= sup_d;
            number_q      <= number_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign number      = number_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;

endmodule
